// File: rtl/rx_deframer_pkg.sv
// Shared types for the UART receive deframer: latched frame config,
// buffered frame entry and FSM state encoding.
package rx_deframer_pkg;

  localparam int UART_MIN_DATA_WIDTH = 5;
  localparam int UART_MAX_DATA_WIDTH = 9;

  typedef struct packed {
    logic [3:0] width;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
    logic       msb_first;
  } rx_cfg_t;

  // Entry layout {brk, frame_err, parity_err, data}; data is right-justified.
  typedef struct packed {
    logic                           brk;
    logic                           frame_err;
    logic                           parity_err;
    logic [UART_MAX_DATA_WIDTH-1:0] data;
  } rx_frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_DONE
  } rx_deframer_state_e;

endpackage

// File: rtl/rx_deframer_fifo.sv
// Small synchronous FIFO of completed frames. Pointers carry one extra MSB
// so full and empty are distinguishable. A push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module rx_frame_fifo
  import rx_deframer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rx_frame_t din,
  input  logic      pop,
  output rx_frame_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  rx_frame_t     mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: assembles data/parity/stop bits from bit-centre strobes
// using a config latched at the start bit, checks parity/framing/break and
// queues the finished frame for the host.
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = $clog2(MAX_DATA_WIDTH+4)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_start,
  input  logic                      rx_shift,
  input  logic                      rx,
  input  logic [3:0]                cfg_data_width,
  input  logic                      cfg_parity_en,
  input  logic                      cfg_parity_odd,
  input  logic                      cfg_stop2,
  input  logic                      cfg_msb_first,
  output logic [MAX_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_parity_err,
  output logic                      rx_frame_err,
  output logic                      rx_break,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      busy
);

  rx_deframer_state_e        state_q, state_d;
  rx_cfg_t                   cfg_q;
  logic [CNT_W-1:0]          cnt_q, width_c, idx;
  logic [MAX_DATA_WIDTH-1:0] data_q;
  logic                      par_q, stop1_q, ferr_q;
  logic                      last_bit, push, pop, full, empty;
  rx_frame_t                 frame, head;

  assign width_c  = CNT_W'(cfg_q.width);
  assign last_bit = (cnt_q == width_c - CNT_W'(1));
  assign idx      = cfg_q.msb_first ? (width_c - CNT_W'(1) - cnt_q) : cnt_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one strobe per bit; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_start) state_d = ST_DATA;
      ST_DATA:   if (rx_shift && last_bit)
                   state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (rx_shift) state_d = ST_STOP1;
      ST_STOP1:  if (rx_shift) state_d = cfg_q.stop2 ? ST_STOP2 : ST_DONE;
      ST_STOP2:  if (rx_shift) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bit capture; data is cleared at start so unused upper bits read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      stop1_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_start) begin
          cfg_q   <= '{width: cfg_data_width, parity_en: cfg_parity_en,
                       parity_odd: cfg_parity_odd, stop2: cfg_stop2,
                       msb_first: cfg_msb_first};
          cnt_q   <= '0;
          data_q  <= '0;
          par_q   <= 1'b0;
          stop1_q <= 1'b1;
          ferr_q  <= 1'b0;
        end
        ST_DATA: if (rx_shift) begin
          data_q[idx] <= rx;
          cnt_q       <= cnt_q + CNT_W'(1);
        end
        ST_PARITY: if (rx_shift) par_q <= rx;
        ST_STOP1: if (rx_shift) begin
          stop1_q <= rx;
          if (!rx) ferr_q <= 1'b1;
        end
        ST_STOP2: if (rx_shift && !rx) ferr_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Frame status from the captured bits; even parity errs on XOR=1.
  always_comb begin
    frame            = '0;
    frame.data       = UART_MAX_DATA_WIDTH'(data_q);
    frame.frame_err  = ferr_q;
    frame.parity_err = cfg_q.parity_en & ((^data_q) ^ par_q ^ cfg_q.parity_odd);
    frame.brk        = (data_q == '0) & ~(cfg_q.parity_en & par_q) & ~stop1_q;
  end

  assign push = (state_q == ST_DONE);
  assign pop  = rx_valid & rx_ready;

  rx_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (frame),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Sticky overrun: a dropped frame wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        overrun <= 1'b0;
    else if (push && full && !pop)  overrun <= 1'b1;
    else if (overrun_clr)           overrun <= 1'b0;
  end

  assign rx_valid      = ~empty;
  assign rx_data       = head.data[MAX_DATA_WIDTH-1:0];
  assign rx_parity_err = head.parity_err;
  assign rx_frame_err  = head.frame_err;
  assign rx_break      = head.brk;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/rx_deframer.md
Name: rx_deframer

Overview:
Parametrised successor to the fixed 8-bit UART receive shifter. Runtime-selectable data width, parity mode, stop-bit count and bit order. Checks parity, framing and break, and buffers completed frames in a small FIFO with a valid/ready output handshake and a sticky overrun flag. Sits between the RX bit-timing/sampling logic (which supplies rx_start/rx_shift strobes) and the host/register interface.

Parameters:
MAX_DATA_WIDTH, 9, widest supported data field (legal cfg_data_width 5..MAX_DATA_WIDTH)
FIFO_DEPTH, 4, frame buffer entries; power of two, >= 2
CNT_W, $clog2(MAX_DATA_WIDTH+4), width of the internal bit counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_start  input  1  1-cycle pulse: start bit validated (start bit is not shifted)
rx_shift  input  1  1-cycle pulse at each subsequent bit centre
rx  input  1  sampled line value, valid when rx_shift=1
cfg_data_width  input  4  data bits per frame, 5..MAX_DATA_WIDTH
cfg_parity_en  input  1  parity bit present
cfg_parity_odd  input  1  1=odd, 0=even parity
cfg_stop2  input  1  1=two stop bits, 0=one
cfg_msb_first  input  1  1=first data bit is MSB of the field
rx_data  output  MAX_DATA_WIDTH  head-of-FIFO data, right-justified, unused upper bits 0
rx_parity_err  output  1  head-entry parity error
rx_frame_err  output  1  head-entry stop-bit error
rx_break  output  1  head entry: all data bits 0, parity (if enabled) 0, first stop bit 0
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer pops head when rx_valid & rx_ready
overrun  output  1  sticky: a completed frame was dropped because the FIFO was full
overrun_clr  input  1  clears overrun
busy  output  1  frame in progress (FSM not IDLE)

Behaviour:
- Reset: FSM IDLE, counter 0, FIFO empty, rx_valid=0, rx_data=0, all error outputs 0, overrun=0, busy=0. Reset mid-frame discards the partial frame and all buffered entries.
- Config latched on rx_start (accepted in IDLE); later config changes do not affect the current frame.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2, DONE.
  - IDLE -> DATA on rx_start. rx_start in any other state is ignored.
  - DATA: each rx_shift stores rx at index cnt (LSB-first) or width-1-cnt (MSB-first). After width bits -> PARITY if enabled, else STOP1.
  - PARITY: one rx_shift captures the parity bit -> STOP1.
  - STOP1: one rx_shift -> STOP2 if cfg_stop2, else DONE.
  - STOP2: one rx_shift -> DONE.
  - DONE: one cycle; push the entry; -> IDLE.
- rx_shift while in IDLE or DONE is ignored.
- Latency: last stop-bit rx_shift at cycle N; push at N+1; rx_valid high at N+2 if the FIFO was empty.
- Parity check: even mode flags an error if XOR(data, parity bit) = 1; odd mode flags an error if it = 0. Parity error is 0 when parity is disabled.
- Framing: frame_err=1 if any stop bit samples 0. Both stop bits are checked in 2-stop mode.
- Break: reported per entry; also implies frame_err=1.
- FIFO entry: {break, frame_err, parity_err, data}. Outputs are driven combinationally from the head entry; rx_data=0 when empty.
- Full and push with no pop in the same cycle: frame dropped, overrun set next cycle.
- Full with simultaneous pop and push: both occur, no overrun.
- Empty and push: entry visible the next cycle; no same-cycle bypass.
- overrun_clr and a new overrun event in the same cycle: overrun stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.

Decomposition:
- Shared package: rx_cfg_t struct (width, parity_en, parity_odd, stop2, msb_first); rx_frame_t struct (break, frame_err, parity_err, data[MAX_DATA_WIDTH-1:0]); FSM state enum rx_deframer_state_e; constants UART_MIN_DATA_WIDTH=5 and UART_MAX_DATA_WIDTH=9.
- Sub-module rx_frame_fifo: generic synchronous FIFO of rx_frame_t with push, pop, full and empty.

Test Plan:
- 8N1, LSB-first, line bits 1,0,1,0,0,1,0,1 then stop 1 -> rx_data=0x0A5, all errors 0, rx_valid rises 2 cycles after the stop rx_shift.
- 7E1 with data 0x41 and parity bit 1 -> rx_data=0x41, parity_err=1. Same frame with parity bit 0 -> parity_err=0.
- 8N2, stop bits 1 then 0 -> frame_err=1, break=0. All-zero data with stop 0 -> break=1, frame_err=1.
- 9-bit, MSB-first, line bits 1,0,0,0,0,0,0,0,1 -> rx_data=0x101. 5-bit frame -> rx_data[8:5]=0.
- FIFO_DEPTH=4, rx_ready=0, five 8N1 frames 0x11..0x55 -> overrun=1; popping returns 0x11..0x44, then rx_valid=0. overrun_clr clears it.
- Assert rst mid-DATA with 2 entries buffered -> rx_valid=0 and busy=0 immediately. The next full frame is received correctly.
